// File: rtl/i2si_bist_pkg.sv
// Shared types and constants for the multi-channel I2S-input BIST pattern generator.
package i2si_bist_pkg;

  typedef enum logic [1:0] {
    RAMP  = 2'd0,
    TRI   = 2'd1,
    CONST = 2'd2,
    LFSR  = 2'd3
  } bist_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } bist_state_e;

  // Galois right-shift tap masks; zero flags an unsupported width.
  function automatic logic [23:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 24'h0000B8;
      12:      return 24'h000E08;
      16:      return 24'h00B400;
      24:      return 24'hE10000;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/i2si_bist_pattern.sv
// Pattern register, triangle direction and next-value logic for the BIST generator.
module i2si_bist_pattern
  import i2si_bist_pkg::*;
#(
  parameter int unsigned VAL_W = 12,
  parameter int unsigned INC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_advance,
  input  bist_mode_e       i_mode,
  input  logic [VAL_W-1:0] i_start,
  input  logic [INC_W-1:0] i_inc,
  input  logic [VAL_W-1:0] i_limit,
  output logic [VAL_W-1:0] o_p
);

  localparam int unsigned    EXT_W = VAL_W + 1;
  localparam logic [VAL_W-1:0] TAPS = VAL_W'(lfsr_taps(VAL_W));

  if (lfsr_taps(VAL_W) == 24'd0) begin : g_bad_width
    $error("i2si_bist_pattern: VAL_W must be 8, 12, 16 or 24");
  end

  logic [VAL_W-1:0] r_p;
  logic             r_down;
  logic [VAL_W-1:0] w_p_nxt;
  logic             w_down_nxt;
  logic [VAL_W-1:0] w_seed;
  logic [EXT_W-1:0] w_inc_x;
  logic [EXT_W-1:0] w_sum;
  logic [EXT_W-1:0] w_lim_x;
  logic [EXT_W-1:0] w_start_inc;

  // Compares are one bit wider than the value so p+inc cannot alias past the limit.
  assign w_inc_x     = EXT_W'(i_inc);
  assign w_sum       = {1'b0, r_p} + w_inc_x;
  assign w_lim_x     = {1'b0, i_limit};
  assign w_start_inc = {1'b0, i_start} + w_inc_x;
  assign w_seed      = (i_mode == LFSR && i_start == '0) ? VAL_W'(1) : i_start;

  always_comb begin
    w_p_nxt    = r_p;
    w_down_nxt = r_down;
    case (i_mode)
      RAMP: begin
        if (w_sum > w_lim_x) w_p_nxt = i_start;
        else                 w_p_nxt = w_sum[VAL_W-1:0];
      end
      TRI: begin
        if (!r_down) begin
          if (w_sum >= w_lim_x) begin
            w_p_nxt    = i_limit;
            w_down_nxt = 1'b1;
          end else begin
            w_p_nxt = w_sum[VAL_W-1:0];
          end
        end else begin
          if ({1'b0, r_p} < w_start_inc) begin
            w_p_nxt    = i_start;
            w_down_nxt = 1'b0;
          end else begin
            w_p_nxt = r_p - VAL_W'(i_inc);
          end
        end
      end
      CONST:   w_p_nxt = i_start;
      LFSR:    w_p_nxt = (r_p >> 1) ^ (r_p[0] ? TAPS : '0);
      default: w_p_nxt = r_p;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_p    <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_p    <= w_seed;
      r_down <= 1'b0;
    end else if (i_advance) begin
      r_p    <= w_p_nxt;
      r_down <= w_down_nxt;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/i2si_bist_gen_mc.sv
// Multi-channel BIST sample source: paces on sck_transition, emits one word per channel slot.
module i2si_bist_gen_mc
  import i2si_bist_pkg::*;
#(
  parameter int unsigned VAL_W        = 12,
  parameter int unsigned INC_W        = 8,
  parameter int unsigned OUT_W        = 32,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned SCK_PER_WORD = 32,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck_transition,
  input  logic             rf_bist_en,
  input  logic [1:0]       rf_bist_mode,
  input  logic [VAL_W-1:0] rf_bist_start_val,
  input  logic [INC_W-1:0] rf_bist_inc,
  input  logic [VAL_W-1:0] rf_bist_up_limit,
  input  logic [VAL_W-1:0] rf_bist_ch_offset,
  output logic [OUT_W-1:0] i2si_bist_out_data,
  output logic [CH_W-1:0]  i2si_bist_out_ch,
  output logic             i2si_bist_out_xfc
);

  localparam int unsigned CNT_W = (SCK_PER_WORD > 1) ? $clog2(SCK_PER_WORD) : 1;
  localparam int unsigned PAD_W = OUT_W - VAL_W;

  bist_state_e      r_state;
  bist_state_e      w_state_nxt;
  logic             w_load;
  logic             w_clear;
  logic             w_word;
  logic             w_adv;
  logic [CNT_W-1:0] r_sck_cnt;
  logic [CH_W-1:0]  r_ch;

  bist_mode_e       r_mode;
  logic [VAL_W-1:0] r_start;
  logic [INC_W-1:0] r_inc;
  logic [VAL_W-1:0] r_limit;
  logic [VAL_W-1:0] r_offset;

  bist_mode_e       w_pat_mode;
  logic [VAL_W-1:0] w_pat_start;
  logic [VAL_W-1:0] w_p;
  logic [VAL_W-1:0] w_ch_off;
  logic [VAL_W-1:0] w_val;

  logic [OUT_W-1:0] r_data;
  logic [CH_W-1:0]  r_out_ch;
  logic             r_xfc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_word      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rf_bist_en) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (!rf_bist_en) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (sck_transition && r_sck_cnt == CNT_W'(SCK_PER_WORD - 1)) begin
          w_word = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_adv = w_word && (r_ch == CH_W'(NUM_CH - 1));

  // Slot and channel counters.
  always_ff @(posedge clk) begin
    if (rst || w_clear || w_load) begin
      r_sck_cnt <= '0;
      r_ch      <= '0;
    end else if (r_state == S_RUN && sck_transition) begin
      if (w_word) begin
        r_sck_cnt <= '0;
        r_ch      <= w_adv ? '0 : r_ch + CH_W'(1);
      end else begin
        r_sck_cnt <= r_sck_cnt + CNT_W'(1);
      end
    end
  end

  // Shadow copy of the configuration, frozen for the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= RAMP;
      r_start  <= '0;
      r_inc    <= '0;
      r_limit  <= '0;
      r_offset <= '0;
    end else if (w_load) begin
      r_mode   <= bist_mode_e'(rf_bist_mode);
      r_start  <= rf_bist_start_val;
      r_inc    <= rf_bist_inc;
      r_limit  <= rf_bist_up_limit;
      r_offset <= rf_bist_ch_offset;
    end
  end

  // Load sees the live registers since the shadow is being written in the same cycle.
  assign w_pat_mode  = w_load ? bist_mode_e'(rf_bist_mode) : r_mode;
  assign w_pat_start = w_load ? rf_bist_start_val : r_start;

  i2si_bist_pattern #(
    .VAL_W (VAL_W),
    .INC_W (INC_W)
  ) u_pattern (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_load    (w_load),
    .i_advance (w_adv),
    .i_mode    (w_pat_mode),
    .i_start   (w_pat_start),
    .i_inc     (r_inc),
    .i_limit   (r_limit),
    .o_p       (w_p)
  );

  assign w_ch_off = VAL_W'(r_ch) * r_offset;
  assign w_val    = w_p + w_ch_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_out_ch <= '0;
      r_xfc    <= 1'b0;
    end else begin
      r_xfc <= w_word;
      if (w_word) begin
        r_data   <= OUT_W'(w_val) << PAD_W;
        r_out_ch <= r_ch;
      end
    end
  end

  assign i2si_bist_out_data = r_data;
  assign i2si_bist_out_ch   = r_out_ch;
  assign i2si_bist_out_xfc  = r_xfc;

endmodule

// File: tb/tb_i2si_bist_gen_mc.sv
// Directed bench for i2si_bist_gen_mc with a cycle-level behavioural reference model.
module tb_i2si_bist_gen_mc;

  localparam int VAL_W = 12;
  localparam int INC_W = 8;
  localparam int OUT_W = 32;
  localparam int NCH   = 2;
  localparam int SPW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sck = 1'b0;
  logic             en  = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [VAL_W-1:0] start_v = '0;
  logic [INC_W-1:0] inc_v = '0;
  logic [VAL_W-1:0] lim_v = '0;
  logic [VAL_W-1:0] off_v = '0;
  logic [OUT_W-1:0] out_data;
  logic             out_ch;
  logic             out_xfc;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] wlog[$];

  // Reference model state (plain integers).
  int m_run = 0, m_cnt = 0, m_ch = 0, m_p = 0, m_up = 1;
  int m_mode = 0, m_start = 0, m_inc = 0, m_lim = 0, m_off = 0;
  logic        exp_xfc = 1'b0;
  logic        exp_ch = 1'b0;
  logic [31:0] exp_data = '0;

  i2si_bist_gen_mc #(
    .VAL_W(VAL_W), .INC_W(INC_W), .OUT_W(OUT_W), .NUM_CH(NCH), .SCK_PER_WORD(SPW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sck_transition     (sck),
    .rf_bist_en         (en),
    .rf_bist_mode       (mode),
    .rf_bist_start_val  (start_v),
    .rf_bist_inc        (inc_v),
    .rf_bist_up_limit   (lim_v),
    .rf_bist_ch_offset  (off_v),
    .i2si_bist_out_data (out_data),
    .i2si_bist_out_ch   (out_ch),
    .i2si_bist_out_xfc  (out_xfc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [32:0] ent(input int i);
    if (i < wlog.size()) return wlog[i];
    return 33'h1_FFFF_FFFF;
  endfunction

  function automatic logic [32:0] word(input int ch, input int v);
    return {ch[0], 32'(v) << 20};
  endfunction

  function automatic int next_p(input int p);
    int b;
    case (m_mode)
      0: return (p + m_inc > m_lim) ? m_start : p + m_inc;
      1: begin
        if (m_up != 0) begin
          if (p + m_inc >= m_lim) begin m_up = 0; return m_lim; end
          return p + m_inc;
        end
        if (p < m_start + m_inc) begin m_up = 1; return m_start; end
        return p - m_inc;
      end
      2: return m_start;
      default: begin
        b = p & 1;
        p = p >> 1;
        return (b != 0) ? (p ^ 32'hE08) : p;
      end
    endcase
  endfunction

  // Compare previous prediction, log DUT words, then predict from inputs sampled at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("xfc", 64'(out_xfc), 64'(exp_xfc));
      chk("ch", 64'(out_ch), 64'(exp_ch));
      chk("data", 64'(out_data), 64'(exp_data));
      if (out_xfc === 1'b1) wlog.push_back({out_ch, out_data});
      exp_xfc = 1'b0;
      if (rst) begin
        m_run = 0; exp_data = '0; exp_ch = 1'b0;
      end else if (!en) begin
        m_run = 0;
      end else if (m_run == 0) begin
        m_run = 1; m_mode = int'(mode); m_start = int'(start_v); m_inc = int'(inc_v);
        m_lim = int'(lim_v); m_off = int'(off_v);
        m_p = (m_mode == 3 && m_start == 0) ? 1 : m_start;
        m_up = 1; m_ch = 0; m_cnt = 0;
      end else if (sck) begin
        m_cnt++;
        if (m_cnt == SPW) begin
          m_cnt = 0;
          exp_xfc = 1'b1;
          exp_data = 32'((m_p + m_ch * m_off) % 4096) << 20;
          exp_ch = m_ch[0];
          m_ch++;
          if (m_ch == NCH) begin m_ch = 0; m_p = next_p(m_p); end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1; step();
      sck = 1'b0; step();
    end
  endtask

  task automatic cfg(input int md, input int st, input int ic, input int lm, input int of);
    mode = 2'(md); start_v = 12'(st); inc_v = 8'(ic); lim_v = 12'(lm); off_v = 12'(of);
  endtask

  task automatic go_idle();
    en = 1'b0; repeat (3) step();
    wlog.delete();
  endtask

  int n_keep;
  int first_rep;

  initial begin
    repeat (3) step();
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_xfc", 64'(out_xfc), 64'h0);
    rst = 1'b0; step();

    // Ramp with channel offset
    cfg(0, 1, 1, 25, 'h100); go_idle();
    en = 1'b1; step();
    pulses(200);
    chk("ramp_count", 64'(wlog.size()), 64'd50);
    chk("ramp_w0", 64'(ent(0)), 64'(word(0, 'h001)));
    chk("ramp_w1", 64'(ent(1)), 64'(word(1, 'h101)));
    chk("ramp_w2", 64'(ent(2)), 64'(word(0, 'h002)));
    chk("ramp_w48", 64'(ent(48)), 64'(word(0, 'h019)));
    pulses(8);
    chk("ramp_wrap", 64'(ent(50)), 64'(word(0, 'h001)));

    // Triangle
    begin
      int tri_exp[8] = '{2, 5, 8, 10, 7, 4, 2, 5};
      cfg(1, 2, 3, 10, 0); go_idle();
      en = 1'b1; step();
      pulses(64);
      for (int k = 0; k < 8; k++)
        chk($sformatf("tri%0d", k), 64'(ent(2 * k)), 64'(word(0, tri_exp[k])));
    end

    // LFSR full period with continuous strobes
    cfg(3, 1, 5, 7, 'h100); go_idle();
    en = 1'b1; step();
    sck = 1'b1; repeat (32776) step();
    sck = 1'b0; step();
    chk("lfsr0", 64'(ent(0)), 64'(word(0, 'h001)));
    chk("lfsr_ch1", 64'(ent(1)), 64'(word(1, 'h101)));
    chk("lfsr1", 64'(ent(2)), 64'(word(0, 'hE08)));
    chk("lfsr2", 64'(ent(4)), 64'(word(0, 'h704)));
    first_rep = -1;
    for (int k = 1; k < 4200; k++)
      if (first_rep < 0 && ent(2 * k) == word(0, 'h001)) first_rep = k;
    chk("lfsr_period", 64'(first_rep), 64'd4095);

    // Shadowing, disable, re-enable
    cfg(0, 1, 1, 25, 'h100); go_idle();
    en = 1'b1; step();
    pulses(8);
    lim_v = 12'd3; start_v = 12'h050;
    pulses(40);
    chk("shadow_f4", 64'(ent(8)), 64'(word(0, 'h005)));
    chk("shadow_f5", 64'(ent(10)), 64'(word(0, 'h006)));
    en = 1'b0; step();
    n_keep = wlog.size();
    pulses(12);
    chk("idle_no_xfc", 64'(wlog.size()), 64'(n_keep));
    wlog.delete();
    en = 1'b1; step();
    pulses(4);
    chk("reen_first", 64'(ent(0)), 64'(word(0, 'h050)));
    // Enable drop coincident with the terminal strobe
    pulses(3);
    en = 1'b0; sck = 1'b1; step();
    sck = 1'b0; repeat (3) step();
    chk("drop_pending", 64'(wlog.size()), 64'd1);

    // Reset two cycles after a transfer
    cfg(0, 1, 1, 25, 'h100); go_idle();
    en = 1'b1; step();
    pulses(4);
    chk("pre_rst_data", 64'(out_data), 64'h0010_0000);
    rst = 1'b1; step();
    chk("mid_rst_data", 64'(out_data), 64'h0);
    chk("mid_rst_ch", 64'(out_ch), 64'h0);
    chk("mid_rst_xfc", 64'(out_xfc), 64'h0);
    pulses(8);
    chk("rst_no_xfc", 64'(wlog.size()), 64'd1);
    rst = 1'b0; step();

    // inc = 0 gives a constant start value
    cfg(0, 7, 0, 25, 'h100); go_idle();
    en = 1'b1; step();
    pulses(24);
    chk("inc0_f0", 64'(ent(0)), 64'(word(0, 'h007)));
    chk("inc0_f2", 64'(ent(4)), 64'(word(0, 'h007)));
    chk("inc0_ch1", 64'(ent(5)), 64'(word(1, 'h107)));

    // start > limit in ramp mode
    cfg(0, 'h30, 1, 'h10, 'h100); go_idle();
    en = 1'b1; step();
    pulses(16);
    chk("ramp_sgtl", 64'(ent(2)), 64'(word(0, 'h030)));

    // Strobe coincident with enable rise is not counted
    cfg(0, 'h20, 1, 25, 'h100); go_idle();
    en = 1'b1; sck = 1'b1; step();
    sck = 1'b0; step();
    pulses(3);
    chk("coinc_none", 64'(wlog.size()), 64'd0);
    pulses(1);
    chk("coinc_one", 64'(wlog.size()), 64'd1);
    chk("coinc_val", 64'(ent(0)), 64'(word(0, 'h020)));

    en = 1'b0; repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
